dma_apb_master: RTL and testbench

DMA_APB_MASTER -- requirements
Module: dma_apb_master

---
 rtl/dma_apb_master_if.sv | 39 +++
 rtl/dma_apb_master.sv | 201 ++++++++++++++++++++
 tb/tb_dma_apb_master.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_apb_master_if.sv
// Bus bundle for dma_apb_master: command push port, response pop port and
// the APB requester signals.
//   master modport : the DMA engine (drives cmd_ready, rsp_*, APB controls)
//   slave modport  : the environment (command source, response sink, APB completer)
interface dma_apb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [12:0] cmd_addr;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [12:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pslverr;
  logic        pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pslverr, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pslverr, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/dma_apb_master.sv
// dma_apb_master: queues read/write commands in a small FIFO and issues them
// one at a time as APB transfers, returning each result through a one-entry
// response buffer.
// Ports:
//   clk    - single clock, all state on rising edge
//   reset  - asynchronous active-low reset
//   pclken - APB clock enable; the APB FSM only advances when high
//   bus    - dma_apb_master_if.master (cmd_*, rsp_*, APB signals)
//   busy   - FIFO non-empty, transfer in progress, or response pending
//   tmo    - sticky timeout flag (0 unless DMA_APB_MASTER_TIMEOUT_EN)
// Optional feature: define DMA_APB_MASTER_TIMEOUT_EN to abort ACCESS phases
// that wait TIMEOUT_CYCLES pclken cycles without pready.
module dma_apb_master #(
  parameter int unsigned CMD_DEPTH      = 4,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pclken,
  dma_apb_master_if.master bus,
  output logic             busy,
  output logic             tmo
);
  localparam int unsigned PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(CMD_DEPTH);

  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 8'd0) begin : g_cfg_check
    $error("dma_apb_master: CMD_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES non-zero");
  end

  typedef struct packed {
    logic        write;
    logic [12:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  cmd_t            mem_q [CMD_DEPTH];
  cmd_t            mem_d [CMD_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;
  cmd_t            head;

  state_t          state_q, state_d;
  logic            psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [12:0]     paddr_q, paddr_d;
  logic [31:0]     pwdata_q, pwdata_d;
  logic            rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;

`ifdef DMA_APB_MASTER_TIMEOUT_EN
  logic [7:0]      tcnt_q, tcnt_d;
  logic            tmo_q, tmo_d;
  assign tmo = tmo_q;
`else
  assign tmo = 1'b0;
`endif

  assign bus.cmd_ready = (count_q != FULL);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign head          = mem_q[rd_ptr_q];

  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (count_q != '0) || (state_q != IDLE) || rsp_valid_q;

  // Command FIFO: runs every clk regardless of pclken.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // APB FSM and response buffer.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;
`ifdef DMA_APB_MASTER_TIMEOUT_EN
    tcnt_d      = tcnt_q;
    tmo_d       = tmo_q;
`endif
    if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;
    if (pclken) begin
      case (state_q)
        IDLE: begin
          // Uses the registered rsp_valid, so a consumed response still
          // costs one idle pclken cycle before the next transfer.
          if (count_q != '0 && !rsp_valid_q) begin
            pop       = 1'b1;
            paddr_d   = head.addr;
            pwrite_d  = head.write;
            pwdata_d  = head.wdata;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            state_d   = SETUP;
          end
        end
        SETUP: begin
          penable_d = 1'b1;
          state_d   = ACCESS;
`ifdef DMA_APB_MASTER_TIMEOUT_EN
          tcnt_d    = '0;
`endif
        end
        ACCESS: begin
          if (bus.pready) begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
            rsp_err_d   = bus.pslverr;
            state_d     = IDLE;
          end
`ifdef DMA_APB_MASTER_TIMEOUT_EN
          // Fires on the TIMEOUT_CYCLES-th waiting ACCESS cycle.
          else if (tcnt_q == TIMEOUT_CYCLES - 8'd1) begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            tmo_d       = 1'b1;
            state_d     = IDLE;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < CMD_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef DMA_APB_MASTER_TIMEOUT_EN
      tcnt_q      <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef DMA_APB_MASTER_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
      tmo_q       <= tmo_d;
`endif
    end
  end
endmodule

// File: tb/tb_dma_apb_master.sv
// Testbench for dma_apb_master: directed commands with hand-computed expected
// responses pushed into a scoreboard; independent monitors check responses
// and the APB transfers as the DUT presents them.
module tb_dma_apb_master;
`ifdef DMA_APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TMO_CYC = 8'd8;
`else
  localparam logic [7:0] TMO_CYC = 8'd255;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pclken = 1'b1;
  logic busy, tmo;

  dma_apb_master_if bus ();

  dma_apb_master #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(TMO_CYC)) dut (
    .clk    (clk),
    .reset  (reset),
    .pclken (pclken),
    .bus    (bus.master),
    .busy   (busy),
    .tmo    (tmo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- APB completer model ----------------
  int          wait_n = 0;
  logic [31:0] rd_cfg = '0;
  logic        err_cfg = 1'b0;
  int          acc_waits = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset)                                          acc_waits <= 0;
    else if (!bus.psel)                                  acc_waits <= 0;
    else if (bus.penable && pclken && !bus.pready)       acc_waits <= acc_waits + 1;
  end
  assign bus.pready  = bus.psel && bus.penable && (acc_waits >= wait_n);
  assign bus.prdata  = rd_cfg;
  assign bus.pslverr = err_cfg && bus.pready;

  // ---------------- pclken generator ----------------
  logic div_mode = 1'b0;
  logic hold_pclk = 1'b0;
  int   ph = 0;
  always @(posedge clk) begin
    #1;
    if (hold_pclk)     pclken = 1'b0;
    else if (div_mode) begin pclken = (ph == 0); ph = (ph + 1) % 3; end
    else               pclken = 1'b1;
  end

  // ---------------- scoreboard queues ----------------
  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { logic w; logic [12:0] a; logic [31:0] d; } apb_t;
  rsp_t sb_q[$];
  apb_t apb_q[$];

  // Response monitor
  always @(negedge clk) begin : rsp_mon
    rsp_t e;
    if (reset && bus.rsp_valid && bus.rsp_ready) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: got rdata 0x%08h err %0b, expected no response", bus.rsp_rdata, bus.rsp_err);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end

  // APB monitor: order, contents and stability of each transfer
  logic        psel_prev = 1'b0;
  int          started = 0;
  int          cur_len = 0;
  int          last_len = 0;
  apb_t        cur;
  always @(negedge clk) begin : apb_mon
    if (!reset) begin
      psel_prev = 1'b0;
    end else begin
      if (bus.psel) begin
        if (!psel_prev) begin
          started++;
          cur_len = 0;
          if (apb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL apb_unexpected: got paddr 0x%03h, expected no transfer", bus.paddr);
            cur = '{w: bus.pwrite, a: bus.paddr, d: bus.pwdata};
          end else begin
            cur = apb_q.pop_front();
            chk("apb_paddr", 32'(bus.paddr), 32'(cur.a));
            chk("apb_pwrite", 32'(bus.pwrite), 32'(cur.w));
            chk("apb_pwdata", bus.pwdata, cur.d);
            chk("apb_setup_penable", 32'(bus.penable), 32'd0);
          end
        end else begin
          chk("apb_stable", {18'd0, bus.pwrite, bus.paddr}, {18'd0, cur.w, cur.a});
        end
        cur_len++;
      end else if (psel_prev) begin
        last_len = cur_len;
      end
      psel_prev = bus.psel;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_cmd(input logic w, input logic [12:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rdata, input logic exp_err);
    logic acc;
    acc = 1'b0;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    apb_q.push_back('{w: w, a: a, d: d});
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL cmd_accept: got no cmd_ready within 300 cycles, expected acceptance");
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
    tick();
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d responses outstanding, expected 0", sb_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();

    // Reset values
    chk("rst_psel", 32'(bus.psel), 32'd0);
    chk("rst_penable", 32'(bus.penable), 32'd0);
    chk("rst_pwrite", 32'(bus.pwrite), 32'd0);
    chk("rst_paddr", 32'(bus.paddr), 32'd0);
    chk("rst_pwdata", bus.pwdata, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    reset = 1'b1;
    tick();

    // Write with immediate pready
    wait_n = 0;
    push_cmd(1'b1, 13'h004, 32'h0000_00A5, 32'h0, 1'b0);
    drain(50);
    chk("wr_psel_cycles", 32'(last_len), 32'd2);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_paddr_hold", 32'(bus.paddr), 32'h004);

    // Read with three wait states
    wait_n = 3;
    rd_cfg = 32'h1234_5678;
    push_cmd(1'b0, 13'h010, 32'h0, 32'h1234_5678, 1'b0);
    drain(50);
    chk("rd_psel_cycles", 32'(last_len), 32'd5);

    // FIFO fill with stalled responses
    wait_n = 0;
    rd_cfg = 32'hCAFE_0000;
    bus.rsp_ready = 1'b0;
    hold_pclk = 1'b1;
    tick(); tick();
    s0 = started;
    push_cmd(1'b1, 13'h020, 32'h11, 32'h0, 1'b0);
    push_cmd(1'b0, 13'h024, 32'h0, 32'hCAFE_0000, 1'b0);
    push_cmd(1'b1, 13'h028, 32'h33, 32'h0, 1'b0);
    push_cmd(1'b0, 13'h02C, 32'h0, 32'hCAFE_0000, 1'b0);
    @(negedge clk);
    chk("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    tick();
    hold_pclk = 1'b0;
    push_cmd(1'b1, 13'h030, 32'h55, 32'h0, 1'b0);
    repeat (20) tick();
    chk("stall_one_issued", 32'(started - s0), 32'd1);
    chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    bus.rsp_ready = 1'b1;
    drain(200);
    chk("fifo_all_issued", 32'(started - s0), 32'd5);

    // pclken 1-of-3 with slave error
    div_mode = 1'b1;
    err_cfg = 1'b1;
    push_cmd(1'b1, 13'h040, 32'hDEAD_BEEF, 32'h0, 1'b1);
    drain(100);
    chk("div_psel_cycles", 32'(last_len), 32'd6);
    div_mode = 1'b0;
    err_cfg = 1'b0;
    tick(); tick();

`ifdef DMA_APB_MASTER_TIMEOUT_EN
    // ACCESS timeout, then a normal transfer
    wait_n = 1000;
    rd_cfg = 32'h0000_0077;
    push_cmd(1'b0, 13'h050, 32'h0, 32'h0, 1'b1);
    drain(100);
    chk("tmo_psel_cycles", 32'(last_len), 32'd9);
    chk("tmo_flag", 32'(tmo), 32'd1);
    wait_n = 0;
    push_cmd(1'b1, 13'h054, 32'h99, 32'h0, 1'b0);
    drain(50);
    chk("post_tmo_psel_cycles", 32'(last_len), 32'd2);
    chk("tmo_sticky", 32'(tmo), 32'd1);
`else
    chk("tmo_tied", 32'(tmo), 32'd0);
`endif

    // Reset during ACCESS with two commands queued
    wait_n = 1000;
    hold_pclk = 1'b1;
    tick(); tick();
    push_cmd(1'b1, 13'h060, 32'h66, 32'h0, 1'b0);
    push_cmd(1'b1, 13'h064, 32'h67, 32'h0, 1'b0);
    push_cmd(1'b1, 13'h068, 32'h68, 32'h0, 1'b0);
    hold_pclk = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = bus.psel && bus.penable;
      end
      chk("rst_mid_access_seen", 32'(seen), 32'd1);
    end
    #2;
    reset = 1'b0;
    sb_q.delete();
    apb_q.delete();
    #1;
    chk("arst_psel", 32'(bus.psel), 32'd0);
    chk("arst_penable", 32'(bus.penable), 32'd0);
    chk("arst_pwrite", 32'(bus.pwrite), 32'd0);
    chk("arst_paddr", 32'(bus.paddr), 32'd0);
    chk("arst_pwdata", bus.pwdata, 32'd0);
    chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tmo", 32'(tmo), 32'd0);
    tick(); tick();
    reset = 1'b1;
    wait_n = 0;
    s0 = started;
    repeat (10) tick();
    chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_no_issue", 32'(started - s0), 32'd0);
    push_cmd(1'b0, 13'h070, 32'h0, 32'hCAFE_0000, 1'b0);
    rd_cfg = 32'hCAFE_0000;
    drain(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
